pwm_multi_core: RTL and testbench

Multi-channel PWM core: one shared prescaled up/down timebase driving CHANNELS independent PWM outputs, each with its own two compare values, alignment mode, polarity and enable. Sits behind the SPI register decoder in the PWM generator top level, which drives the flat register port below. Successor to the single-channel 8-bit PWM path: wider parametrised counters, multiple channels, per-channel polarity, wrap tick, optional glitch-free shadow updates.

---
 rtl/pwm_multi_core.sv | 201 ++++++++++++++++++++
 tb/tb_pwm_multi_core.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_core.sv
// pwm_multi_core: shared prescaled up/down timebase driving CHANNELS PWM outputs.
// Define PWM_MULTI_SHADOW_EN to double-buffer PERIOD/CMP1/CMP2/mode/invert until wrap.
module pwm_multi_core #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 4,
  parameter int PSC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic                cfg_re,
  input  logic [7:0]          cfg_addr,
  input  logic [WIDTH-1:0]    cfg_wdata,
  output logic [WIDTH-1:0]    cfg_rdata,
  output logic [WIDTH-1:0]    counter_val,
  output logic                period_tick,
  output logic [CHANNELS-1:0] pwm_out
);
  logic [WIDTH-1:0]     per_r, per_nx, per_a;
  logic [PSC_WIDTH-1:0] psc_r, psc_q, psc_d;
  logic                 ctrl_en, ctrl_up;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic                 wr_per, wr_psc, wr_ctrl, creset, step, wrap;
  logic [WIDTH-1:0]     cmp1_r [CHANNELS];
  logic [WIDTH-1:0]     cmp2_r [CHANNELS];
  logic [WIDTH-1:0]     cmp1_nx [CHANNELS];
  logic [WIDTH-1:0]     cmp2_nx [CHANNELS];
  logic [WIDTH-1:0]     cmp1_a [CHANNELS];
  logic [WIDTH-1:0]     cmp2_a [CHANNELS];
  logic [1:0]           mode_r [CHANNELS];
  logic [1:0]           mode_nx [CHANNELS];
  logic [1:0]           mode_a [CHANNELS];
  logic [CHANNELS-1:0]  en_r, inv_r, inv_nx, inv_a;
  logic [CHANNELS-1:0]  wr_c1, wr_c2, wr_cc, pwm_d;
  logic [WIDTH-1:0]     rd_c;

  // *_nx is the register-file value after this cycle's write
  always_comb begin
    wr_per  = cfg_we && (cfg_addr == 8'h00);
    wr_psc  = cfg_we && (cfg_addr == 8'h01);
    wr_ctrl = cfg_we && (cfg_addr == 8'h02);
    creset  = wr_ctrl && cfg_wdata[2];
    per_nx  = wr_per ? cfg_wdata : per_r;
    wr_c1   = '0;
    wr_c2   = '0;
    wr_cc   = '0;
    inv_nx  = inv_r;
    for (int n = 0; n < CHANNELS; n++) begin
      wr_c1[n]   = cfg_we && (cfg_addr == 8'(16 + 4*n));
      wr_c2[n]   = cfg_we && (cfg_addr == 8'(17 + 4*n));
      wr_cc[n]   = cfg_we && (cfg_addr == 8'(18 + 4*n));
      cmp1_nx[n] = wr_c1[n] ? cfg_wdata : cmp1_r[n];
      cmp2_nx[n] = wr_c2[n] ? cfg_wdata : cmp2_r[n];
      mode_nx[n] = wr_cc[n] ? cfg_wdata[2:1] : mode_r[n];
      if (wr_cc[n]) inv_nx[n] = cfg_wdata[3];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_r   <= '0;
      psc_r   <= '0;
      ctrl_en <= 1'b0;
      ctrl_up <= 1'b0;
      en_r    <= '0;
      inv_r   <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        cmp1_r[n] <= '0;
        cmp2_r[n] <= '0;
        mode_r[n] <= '0;
      end
    end else begin
      per_r <= per_nx;
      inv_r <= inv_nx;
      if (wr_psc) psc_r <= PSC_WIDTH'(cfg_wdata);
      if (wr_ctrl) begin
        ctrl_en <= cfg_wdata[0];
        ctrl_up <= cfg_wdata[1];
      end
      for (int n = 0; n < CHANNELS; n++) begin
        cmp1_r[n] <= cmp1_nx[n];
        cmp2_r[n] <= cmp2_nx[n];
        mode_r[n] <= mode_nx[n];
        if (wr_cc[n]) en_r[n] <= cfg_wdata[0];
      end
    end
  end

`ifdef PWM_MULTI_SHADOW_EN
  logic copy;
  assign copy = wrap || creset || !ctrl_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_a <= '0;
      inv_a <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        cmp1_a[n] <= '0;
        cmp2_a[n] <= '0;
        mode_a[n] <= '0;
      end
    end else if (copy) begin
      per_a <= per_nx;
      inv_a <= inv_nx;
      for (int n = 0; n < CHANNELS; n++) begin
        cmp1_a[n] <= cmp1_nx[n];
        cmp2_a[n] <= cmp2_nx[n];
        mode_a[n] <= mode_nx[n];
      end
    end
  end
`else
  always_comb begin
    per_a = per_r;
    inv_a = inv_r;
    for (int n = 0; n < CHANNELS; n++) begin
      cmp1_a[n] = cmp1_r[n];
      cmp2_a[n] = cmp2_r[n];
      mode_a[n] = mode_r[n];
    end
  end
`endif

  // counter_reset overrides any step or wrap in the same cycle
  always_comb begin
    step  = ctrl_en && (psc_q >= psc_r);
    wrap  = 1'b0;
    cnt_d = cnt_q;
    psc_d = psc_q;
    if (ctrl_en) psc_d = step ? '0 : psc_q + 1'b1;
    if (step) begin
      if (ctrl_up) begin
        if (cnt_q >= per_a) begin
          cnt_d = '0;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (cnt_q == '0) begin
        cnt_d = per_nx;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
    if (creset) begin
      psc_d = '0;
      cnt_d = cfg_wdata[1] ? '0 : per_nx;
      wrap  = 1'b0;
    end
  end

  always_comb begin
    pwm_d = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      logic raw;
      case (mode_a[n])
        2'b00:   raw = (cmp1_a[n] != '0) && (cnt_q <= cmp1_a[n]);
        2'b01:   raw = (cnt_q >= cmp1_a[n]);
        2'b10:   raw = (cmp1_a[n] < cmp2_a[n]) && (cnt_q >= cmp1_a[n]) && (cnt_q < cmp2_a[n]);
        default: raw = 1'b0;
      endcase
      pwm_d[n] = en_r[n] & (raw ^ inv_a[n]);
    end
  end

  always_comb begin
    rd_c = '0;
    case (cfg_addr)
      8'h00:   rd_c = per_r;
      8'h01:   rd_c = WIDTH'(psc_r);
      8'h02:   rd_c = WIDTH'({ctrl_up, ctrl_en});
      8'h03:   rd_c = cnt_q;
      default: rd_c = '0;
    endcase
    for (int n = 0; n < CHANNELS; n++) begin
      if (cfg_addr == 8'(16 + 4*n)) rd_c = cmp1_r[n];
      if (cfg_addr == 8'(17 + 4*n)) rd_c = cmp2_r[n];
      if (cfg_addr == 8'(18 + 4*n)) rd_c = WIDTH'({inv_r[n], mode_r[n], en_r[n]});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      psc_q       <= '0;
      period_tick <= 1'b0;
      pwm_out     <= '0;
      cfg_rdata   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      psc_q       <= psc_d;
      period_tick <= wrap;
      pwm_out     <= pwm_d;
      if (cfg_re) cfg_rdata <= rd_c;
    end
  end

  assign counter_val = cnt_q;

endmodule

// File: tb/tb_pwm_multi_core.sv
// tb_pwm_multi_core: directed register/timebase/PWM vectors with hand-computed expectations.
// Shadow-dependent expectations follow PWM_MULTI_SHADOW_EN.
module tb_pwm_multi_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic        cfg_re = 1'b0;
  logic [7:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic [15:0] cfg_rdata;
  logic [15:0] counter_val;
  logic        period_tick;
  logic [3:0]  pwm_out;

  int errors = 0;
  int checks = 0;

  pwm_multi_core #(.WIDTH(16), .CHANNELS(4), .PSC_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .counter_val(counter_val),
    .period_tick(period_tick), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // all tasks start and end just after a falling edge
  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [15:0] d);
    cfg_re = 1'b1; cfg_addr = a;
    @(negedge clk);
    cfg_re = 1'b0;
    d = cfg_rdata;
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    @(negedge clk);
    while (!period_tick && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, period_tick, 1'b1);
  endtask

  initial begin
    logic [15:0] d;
    logic [3:0]  e;
    int          h0, h1, h2, tk, p;
    int          dseq[6] = '{4, 3, 2, 1, 0, 4};

    repeat (2) @(negedge clk);
    check("rst_pwm", pwm_out, 4'h0);
    check("rst_cnt", counter_val, 16'h0);
    check("rst_tick", period_tick, 1'b0);
    check("rst_rdata", cfg_rdata, 16'h0);
    rst = 1'b0;
    @(negedge clk);
    rd(8'h00, d); check("rst_period", d, 16'h0);

    // three channels over PERIOD=7, no prescale
    wr(8'h00, 16'd7);
    wr(8'h01, 16'd0);
    wr(8'h10, 16'd3); wr(8'h12, 16'h0001);
    wr(8'h14, 16'd2); wr(8'h15, 16'd6); wr(8'h16, 16'h0005);
    wr(8'h18, 16'd5); wr(8'h1A, 16'h000B);
    wr(8'h02, 16'h0003);
    wait_tick("sync_up");
    h0 = 0; h1 = 0; h2 = 0; tk = 0;
    for (int i = 0; i < 16; i++) begin
      p = (i + 7) % 8;
      e = {1'b0, !(p >= 5), (p >= 2 && p < 6), (p <= 3)};
      check($sformatf("up_cnt%0d", i), counter_val, 16'(i % 8));
      check($sformatf("up_pwm%0d", i), pwm_out, e);
      check($sformatf("up_tick%0d", i), period_tick, (i % 8) == 0);
      h0 += pwm_out[0]; h1 += pwm_out[1]; h2 += pwm_out[2]; tk += period_tick;
      @(negedge clk);
    end
    check("duty_ch0", h0, 8);
    check("duty_ch1", h1, 8);
    check("duty_ch2", h2, 10);
    check("ticks", tk, 2);

    // degenerate compares: CMP1=0 left, CMP1=CMP2 range
    wr(8'h10, 16'd0);
    wr(8'h14, 16'd5); wr(8'h15, 16'd5);
    repeat (10) @(negedge clk);
    h0 = 0; h1 = 0;
    for (int i = 0; i < 24; i++) begin
      h0 += pwm_out[0]; h1 += pwm_out[1];
      @(negedge clk);
    end
    check("low_ch0_cmp0", h0, 0);
    check("low_ch1_eq", h1, 0);

    rd(8'h14, d); check("rd_c1_ch1", d, 16'd5);
    rd(8'h15, d); check("rd_c2_ch1", d, 16'd5);
    rd(8'h16, d); check("rd_cc_ch1", d, 16'h0005);
    rd(8'h1A, d); check("rd_cc_ch2", d, 16'h000B);
    rd(8'h02, d); check("rd_ctrl", d, 16'h0003);
    rd(8'h05, d); check("rd_unmapped", d, 16'h0);
    rd(8'h13, d); check("rd_ch_gap", d, 16'h0);
    wr(8'h20, 16'h0055);
    rd(8'h20, d); check("rd_ch4", d, 16'h0);

    // compare update mid-period (counter=2)
    wr(8'h10, 16'd3);
    wait_tick("sync_sh");
    repeat (2) @(negedge clk);
    wr(8'h10, 16'd1);
    check("sh_cnt", counter_val, 16'd3);
`ifdef PWM_MULTI_SHADOW_EN
    @(negedge clk); check("sh_pwm", pwm_out[0], 1'b1);
`else
    @(negedge clk); check("sh_pwm", pwm_out[0], 1'b0);
`endif
    wait_tick("sync_sh2");
    h0 = 0;
    for (int i = 0; i < 8; i++) begin
      h0 += pwm_out[0];
      @(negedge clk);
    end
    check("duty_cmp1", h0, 2);

    // simultaneous write and read return the old value
    cfg_we = 1'b1; cfg_re = 1'b1; cfg_addr = 8'h10; cfg_wdata = 16'd9;
    @(negedge clk);
    cfg_we = 1'b0; cfg_re = 1'b0;
    check("rw_old", cfg_rdata, 16'd1);
    rd(8'h10, d); check("rw_new", d, 16'd9);

    // down mode, prescale 3, PERIOD=4, started by counter_reset
    wr(8'h01, 16'd3);
    wr(8'h00, 16'd4);
    wr(8'h02, 16'h0005);
    for (int i = 0; i < 24; i++) begin
      check($sformatf("dn_cnt%0d", i), counter_val, 16'(dseq[i/4]));
      check($sformatf("dn_tick%0d", i), period_tick, i == 20);
      @(negedge clk);
    end
    rd(8'h01, d); check("rd_psc", d, 16'd3);

    // asynchronous reset mid-run
    rst = 1'b1;
    #1;
    check("arst_cnt", counter_val, 16'h0);
    check("arst_pwm", pwm_out, 4'h0);
    check("arst_rdata", cfg_rdata, 16'h0);
    @(negedge clk);
    check("arst_tick", period_tick, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cnt", counter_val, 16'h0);
    check("post_rst_tick", period_tick, 1'b0);
    rd(8'h00, d); check("post_rst_per", d, 16'h0);

    // counter_reset coincident with wrap
    wr(8'h00, 16'd3);
    wr(8'h10, 16'd1); wr(8'h12, 16'h0001);
    wr(8'h02, 16'h0003);
    wait_tick("sync_cr");
    repeat (3) @(negedge clk);
    check("cr_pre", counter_val, 16'd3);
    wr(8'h02, 16'h0007);
    check("cr_cnt", counter_val, 16'h0);
    check("cr_tick", period_tick, 1'b0);
    @(negedge clk);
    check("cr_next", counter_val, 16'd1);

    // counter_en=0 holds the counter
    wr(8'h02, 16'h0002);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("hold%0d", i), counter_val, 16'd2);
      @(negedge clk);
    end
    rd(8'h03, d); check("rd_counter", d, 16'd2);
    rd(8'h02, d); check("rd_ctrl_off", d, 16'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
